// File: rtl/bch_gf16_pkg.sv
// Shared GF(16) arithmetic, FSM states and BCH(15,k) generator constants
// for the streaming BCH decoder (optional BCH_STATS_EN counters live in the top).
package bch_gf16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYND,
    BM,
    CHIEN,
    DONE
  } state_e;

  typedef logic [3:0] gf_t;

  // alpha^i for x^4+x+1
  localparam gf_t ALOG [0:14] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  localparam logic [3:0] LOG [0:15] = '{
    4'd0, 4'd0, 4'd1, 4'd4, 4'd2, 4'd8, 4'd5, 4'd10,
    4'd3, 4'd14, 4'd9, 4'd7, 4'd6, 4'd13, 4'd11, 4'd12
  };

  localparam logic [14:0] G_T1 = 15'h0013;
  localparam logic [14:0] G_T2 = 15'h01D1;
  localparam logic [14:0] G_T3 = 15'h0537;

  function automatic gf_t gf_alpha(input int e);
    return ALOG[4'(e % 15)];
  endfunction

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    logic [4:0] s;
    s = {1'b0, LOG[a]} + {1'b0, LOG[b]};
    if (s >= 5'd15) s = s - 5'd15;
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return ALOG[s[3:0]];
  endfunction

  function automatic gf_t gf_sq(input gf_t a);
    return gf_mul(a, a);
  endfunction

  function automatic gf_t gf_inv(input gf_t a);
    logic [3:0] e;
    e = 4'd15 - LOG[a];
    if (e == 4'd15) e = 4'd0;
    if (a == 4'h0) return 4'h0;
    return ALOG[e];
  endfunction

endpackage

// File: rtl/bch_gf16_chien.sv
// Combinational Chien search: evaluates a degree<=3 locator at all 15
// positions; position i is a root when lambda(alpha^-i) == 0.
module bch_gf16_chien
  import bch_gf16_pkg::*;
(
  input  logic [15:0] lam_i,
  output logic [14:0] mask_o,
  output logic [3:0]  cnt_o
);

  gf_t v;

  always_comb begin
    mask_o = '0;
    cnt_o  = '0;
    v      = '0;
    for (int i = 0; i < 15; i++) begin
      v = lam_i[3:0];
      for (int k = 1; k < 4; k++)
        v ^= gf_mul(lam_i[4*k +: 4], gf_alpha(k * (15 - i)));
      mask_o[i] = (v == 4'h0);
      cnt_o = cnt_o + {3'b000, mask_o[i]};
    end
  end

endmodule

// File: rtl/bch_gf16_stream_dec.sv
// Streaming binary BCH(15,k) decoder, t=0..3, syndrome/BM/Chien FSM.
// Define BCH_STATS_EN to add the word/corrected/uncorrectable counters.
module bch_gf16_stream_dec
  import bch_gf16_pkg::*;
#(
  parameter int T_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] data_out,
  output logic [1:0]  err_cnt,
  output logic        error_flag,
  output logic        uncorrectable
`ifdef BCH_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] cnt_words,
  output logic [15:0] cnt_corr,
  output logic [15:0] cnt_uncorr
`endif
);

  localparam logic [1:0] TCAP = 2'(T_MAX);

  state_e      state_q;
  logic [14:0] word_q;
  logic [1:0]  t_q;
  logic [1:0]  k_q;
  logic [2:0]  len_q;
  gf_t         b_q;
  gf_t         s_q   [1:6];
  gf_t         lam_q [0:6];
  gf_t         bx_q  [0:6];

  logic        out_valid_q;
  logic [14:0] data_out_q;
  logic [1:0]  err_cnt_q;
  logic        error_flag_q;
  logic        unc_q;

  gf_t         s_d   [1:6];
  gf_t         lam_d [0:6];
  gf_t         bx_d  [0:6];
  gf_t         b_d;
  logic [2:0]  len_d;

  logic [1:0]  t_in;
  logic        synd_nz;
  gf_t         sv [0:7];
  gf_t         d;
  gf_t         coef;
  logic [2:0]  n_s;
  logic [14:0] mask;
  logic [3:0]  roots;
  logic [14:0] res_data;
  logic [1:0]  res_cnt;
  logic        res_ef;
  logic        res_unc;

  function automatic gf_t synd(input logic [14:0] w, input int j);
    gf_t s;
    s = '0;
    for (int i = 0; i < 15; i++)
      if (w[i]) s ^= gf_alpha(i * j);
    return s;
  endfunction

  assign t_in     = (mode > TCAP) ? TCAP : mode;
  assign in_ready = (state_q == IDLE) & ~rst;

  // Odd syndromes by evaluation, even ones as squares of S(j/2)
  always_comb begin
    for (int j = 1; j <= 5; j += 2)
      s_d[j] = synd(word_q, j);
    for (int j = 2; j <= 6; j += 2)
      s_d[j] = gf_sq(s_d[j/2]);
  end

  always_comb begin
    synd_nz = 1'b0;
    for (int j = 1; j <= 6; j++)
      if (j <= 2 * int'(t_q) && s_q[j] != 4'h0)
        synd_nz = 1'b1;
  end

  // One binary BM step on odd syndrome index n = 2k+1
  always_comb begin
    n_s   = {k_q, 1'b1};
    sv[0] = '0;
    sv[7] = '0;
    for (int j = 1; j <= 6; j++)
      sv[j] = s_q[j];
    d = '0;
    for (int i = 0; i < 7; i++)
      if (3'(i) < n_s)
        d ^= gf_mul(lam_q[i], sv[n_s - 3'(i)]);
    coef = gf_mul(d, gf_inv(b_q));
    for (int i = 0; i < 7; i++)
      lam_d[i] = lam_q[i] ^ gf_mul(coef, bx_q[i]);
    b_d     = b_q;
    len_d   = len_q;
    bx_d[0] = '0;
    bx_d[1] = '0;
    if (d != 4'h0 && len_q <= {1'b0, k_q}) begin
      for (int i = 2; i < 7; i++)
        bx_d[i] = lam_q[i-2];
      len_d = n_s - len_q;
      b_d   = d;
    end else begin
      for (int i = 2; i < 7; i++)
        bx_d[i] = bx_q[i-2];
    end
  end

  bch_gf16_chien u_chien (
    .lam_i  ({lam_q[3], lam_q[2], lam_q[1], lam_q[0]}),
    .mask_o (mask),
    .cnt_o  (roots)
  );

  always_comb begin
    res_data = word_q;
    res_cnt  = '0;
    res_ef   = 1'b0;
    res_unc  = 1'b0;
    if (t_q != 2'd0 && synd_nz) begin
      res_ef = 1'b1;
      if (len_q > {1'b0, t_q} || roots != {1'b0, len_q}) begin
        res_unc = 1'b1;
      end else begin
        res_data = word_q ^ mask;
        res_cnt  = len_q[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      t_q          <= '0;
      k_q          <= '0;
      len_q        <= '0;
      b_q          <= 4'h1;
      for (int j = 1; j <= 6; j++)
        s_q[j] <= '0;
      for (int i = 0; i < 7; i++) begin
        lam_q[i] <= '0;
        bx_q[i]  <= '0;
      end
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      err_cnt_q    <= '0;
      error_flag_q <= 1'b0;
      unc_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_q  <= data_in;
            t_q     <= t_in;
            state_q <= SYND;
          end
        end
        SYND: begin
          s_q <= s_d;
          for (int i = 0; i < 7; i++) begin
            lam_q[i] <= (i == 0) ? 4'h1 : 4'h0;
            bx_q[i]  <= (i == 1) ? 4'h1 : 4'h0;
          end
          len_q   <= '0;
          b_q     <= 4'h1;
          k_q     <= '0;
          state_q <= (t_q == 2'd0) ? CHIEN : BM;
        end
        BM: begin
          lam_q <= lam_d;
          bx_q  <= bx_d;
          len_q <= len_d;
          b_q   <= b_d;
          k_q   <= k_q + 2'd1;
          if (k_q == t_q - 2'd1)
            state_q <= CHIEN;
        end
        CHIEN: begin
          data_out_q   <= res_data;
          err_cnt_q    <= res_cnt;
          error_flag_q <= res_ef;
          unc_q        <= res_unc;
          out_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign data_out      = data_out_q;
  assign err_cnt       = err_cnt_q;
  assign error_flag    = error_flag_q;
  assign uncorrectable = unc_q;

`ifdef BCH_STATS_EN
  logic [15:0] cnt_words_q;
  logic [15:0] cnt_corr_q;
  logic [15:0] cnt_uncorr_q;
  logic        hs;

  assign hs = out_valid_q & out_ready;

  // Saturating counters; clear wins over a same-cycle handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_words_q  <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (stats_clr) begin
      cnt_words_q  <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (hs) begin
      if (cnt_words_q != 16'hFFFF)
        cnt_words_q <= cnt_words_q + 16'd1;
      if (err_cnt_q != 2'd0 && cnt_corr_q != 16'hFFFF)
        cnt_corr_q <= cnt_corr_q + 16'd1;
      if (unc_q && cnt_uncorr_q != 16'hFFFF)
        cnt_uncorr_q <= cnt_uncorr_q + 16'd1;
    end
  end

  assign cnt_words  = cnt_words_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule

// File: tb/tb_bch_gf16_stream_dec.sv
// Bench for bch_gf16_stream_dec: directed table, corner sequences and
// random words checked against a brute-force bounded-distance decoder.
module tb_bch_gf16_stream_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid, in_ready;
  logic [14:0] data_in;
  logic        out_valid, out_ready;
  logic [14:0] data_out;
  logic [1:0]  err_cnt;
  logic        error_flag, uncorrectable;

  logic        in_valid2, in_ready2, out_valid2;
  logic [14:0] data_out2;
  logic [1:0]  err_cnt2;
  logic        ef2, unc2;

`ifdef BCH_STATS_EN
  logic        stats_clr;
  logic [15:0] cnt_words, cnt_corr, cnt_uncorr;
  logic [15:0] cw2, cc2, cu2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bch_gf16_stream_dec #(.T_MAX(3)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .err_cnt(err_cnt), .error_flag(error_flag),
    .uncorrectable(uncorrectable)
`ifdef BCH_STATS_EN
    , .stats_clr(stats_clr), .cnt_words(cnt_words),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
`endif
  );

  bch_gf16_stream_dec #(.T_MAX(2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid2), .in_ready(in_ready2), .data_in(data_in),
    .out_valid(out_valid2), .out_ready(out_ready), .data_out(data_out2),
    .err_cnt(err_cnt2), .error_flag(ef2), .uncorrectable(unc2)
`ifdef BCH_STATS_EN
    , .stats_clr(stats_clr), .cnt_words(cw2),
    .cnt_corr(cc2), .cnt_uncorr(cu2)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [14:0] gpoly(input int t);
    case (t)
      1: return 15'h0013;
      2: return 15'h01D1;
      default: return 15'h0537;
    endcase
  endfunction

  function automatic int gdeg(input int t);
    case (t)
      1: return 4;
      2: return 8;
      default: return 10;
    endcase
  endfunction

  function automatic bit is_cw(input logic [14:0] w, input int t);
    logic [14:0] r;
    logic [14:0] g;
    int dg;
    r = w;
    g = gpoly(t);
    dg = gdeg(t);
    for (int i = 14; i >= dg; i--)
      if (r[i]) r ^= g << (i - dg);
    return r == 15'd0;
  endfunction

  function automatic logic [14:0] encode(input logic [14:0] msg, input int t);
    logic [14:0] cw;
    cw = '0;
    for (int i = 0; i < 15 - gdeg(t); i++)
      if (msg[i]) cw ^= gpoly(t) << i;
    return cw;
  endfunction

  // Bounded-distance decoding: any pattern of weight <= t reaching a codeword
  task automatic ref_dec(input int t, input logic [14:0] w,
                         output logic [14:0] od, output int oc,
                         output int oef, output int ounc);
    bit found;
    od = w; oc = 0; oef = 0; ounc = 0;
    if (t != 0 && !is_cw(w, t)) begin
      oef = 1;
      ounc = 1;
      found = 0;
      for (int e = 1; e < 32768 && !found; e++) begin
        if ($countones(15'(e)) <= t && is_cw(w ^ 15'(e), t)) begin
          found = 1;
          od = w ^ 15'(e);
          oc = $countones(15'(e));
          ounc = 0;
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] m, input logic [14:0] d, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    mode = m;
    data_in = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = 2'($urandom);
    data_in = 15'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [14:0] d;
    logic [14:0] xd;
    int          xc;
    int          xf;
    int          xu;
    int          xl;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lat;
    logic [14:0] od;
    int oc, oef, ounc;

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, t, nerr, oc, oef, ounc, r;
    logic [14:0] cw, e, w, od;

    tbl[0] = '{2'd2, 15'h41D0, 15'h01D1, 2, 1, 0, 4};
    tbl[1] = '{2'd1, 15'h0113, 15'h0013, 1, 1, 0, 3};
    tbl[2] = '{2'd3, 15'h7537, 15'h0537, 3, 1, 0, 5};
    tbl[3] = '{2'd2, 15'h000B, 15'h000B, 0, 1, 1, 4};
    tbl[4] = '{2'd0, 15'h5A5A, 15'h5A5A, 0, 0, 0, 2};
    tbl[5] = '{2'd1, 15'h0013, 15'h0013, 0, 0, 0, 3};
    tbl[6] = '{2'd3, 15'h0537, 15'h0537, 0, 0, 0, 5};

    rst = 1'b1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    out_ready = 1'b0;
    mode = '0;
    data_in = '0;
`ifdef BCH_STATS_EN
    stats_clr = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_flags", int'({err_cnt, error_flag, uncorrectable}), 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].m, tbl[i].d, lat);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].xl);
      chk($sformatf("vec%0d_data", i), int'(data_out), int'(tbl[i].xd));
      chk($sformatf("vec%0d_cnt", i), int'(err_cnt), tbl[i].xc);
      chk($sformatf("vec%0d_flag", i), int'(error_flag), tbl[i].xf);
      chk($sformatf("vec%0d_unc", i), int'(uncorrectable), tbl[i].xu);
      ack();
    end

    // Back-pressure: result held, input ignored until after the handshake
    send(2'd1, 15'h0113, lat);
    mode = 2'd0;
    data_in = 15'h1234;
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_data", int'(data_out), 15'h0013);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_cnt", int'(err_cnt), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("no_same_cycle_accept", int'(in_ready), 1);
    chk("ack_valid_low", int'(out_valid), 0);
    in_valid = 1'b0;

    // Reset during BM
    mode = 2'd3;
    data_in = 15'h7537;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_data_out", int'(data_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", int'(in_ready), 1);
    chk("midrst_rel_valid", int'(out_valid), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_result", int'(out_valid), 0);

    // Mode clipping on the T_MAX=2 instance
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 15'h41D0 : 15'h7537;
      ref_dec(2, w, od, oc, oef, ounc);
      mode = 2'd3;
      data_in = w;
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      chk($sformatf("clip%0d_lat", k), lat, 4);
      chk($sformatf("clip%0d_data", k), int'(data_out2), int'(od));
      chk($sformatf("clip%0d_cnt", k), int'(err_cnt2), oc);
      chk($sformatf("clip%0d_unc", k), int'(unc2), ounc);
      ack();
    end

    // Random codewords with 0..t+2 errors vs reference
    for (int n = 0; n < 100; n++) begin
      t = $urandom_range(0, 3);
      if (t == 0) begin
        w = 15'($urandom);
      end else begin
        cw = encode(15'($urandom), t);
        r = $urandom_range(0, 9);
        nerr = (r < 8) ? (r % (t + 1)) : (t + 1 + (r - 8));
        e = '0;
        while ($countones(e) < nerr)
          e[$urandom_range(0, 14)] = 1'b1;
        w = cw ^ e;
      end
      ref_dec(t, w, od, oc, oef, ounc);
      send(2'(t), w, lat);
      chk("rnd_lat", lat, 2 + t);
      chk("rnd_data", int'(data_out), int'(od));
      chk("rnd_cnt", int'(err_cnt), oc);
      chk("rnd_flag", int'(error_flag), oef);
      chk("rnd_unc", int'(uncorrectable), ounc);
      ack();
    end

`ifdef BCH_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    send(2'd1, 15'h0013, lat);
    ack();
    send(2'd1, 15'h0113, lat);
    ack();
    send(2'd2, 15'h000B, lat);
    ack();
    chk("stats_words", int'(cnt_words), 3);
    chk("stats_corr", int'(cnt_corr), 1);
    chk("stats_uncorr", int'(cnt_uncorr), 1);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("stats_clr", int'({cnt_words, cnt_corr, cnt_uncorr}), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
